// File: rtl/dlx_pipe_pkg.sv
// Shared widths, ALU opcodes and register constants for the DLX pipeline.
package dlx_pipe_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned RA_W   = 5;
    localparam int unsigned OP_W   = 5;

    localparam logic [OP_W-1:0] ALU_AND = 5'd0;
    localparam logic [OP_W-1:0] ALU_OR  = 5'd1;
    localparam logic [OP_W-1:0] ALU_ADD = 5'd2;
    localparam logic [OP_W-1:0] ALU_SUB = 5'd3;
    localparam logic [OP_W-1:0] ALU_LHI = 5'd12;

    // r0 is hard-wired zero and is never a forwarding target.
    localparam logic [RA_W-1:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/fwd_mux.sv
// Forwarding select for one source register: EX > MEM > WB > register file.
module fwd_mux #(
    parameter int unsigned DATA_W = dlx_pipe_pkg::DATA_W,
    parameter int unsigned RA_W   = dlx_pipe_pkg::RA_W
) (
    input  logic [RA_W-1:0]   rs_i,
    input  logic [DATA_W-1:0] rf_val_i,
    input  logic              ex_en_i,
    input  logic [RA_W-1:0]   ex_rd_i,
    input  logic [DATA_W-1:0] ex_val_i,
    input  logic              mem_en_i,
    input  logic [RA_W-1:0]   mem_rd_i,
    input  logic [DATA_W-1:0] mem_val_i,
    input  logic              wb_en_i,
    input  logic [RA_W-1:0]   wb_rd_i,
    input  logic [DATA_W-1:0] wb_val_i,
    output logic [DATA_W-1:0] val_o
);

    logic rs_nz;
    assign rs_nz = (rs_i != RA_W'(dlx_pipe_pkg::REG_ZERO));

    // Youngest matching producer wins; r0 always reads the register file.
    always_comb begin
        val_o = rf_val_i;
        if (rs_nz && ex_en_i && (ex_rd_i == rs_i)) begin
            val_o = ex_val_i;
        end else if (rs_nz && mem_en_i && (mem_rd_i == rs_i)) begin
            val_o = mem_val_i;
        end else if (rs_nz && wb_en_i && (wb_rd_i == rs_i)) begin
            val_o = wb_val_i;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding and load-use interlock.
module id_ex_stage #(
    parameter int unsigned DATA_W = dlx_pipe_pkg::DATA_W,
    parameter int unsigned RA_W   = dlx_pipe_pkg::RA_W,
    parameter int unsigned OP_W   = dlx_pipe_pkg::OP_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [RA_W-1:0]   id_rs1,
    input  logic [RA_W-1:0]   id_rs2,
    input  logic [RA_W-1:0]   id_rd,
    input  logic [DATA_W-1:0] id_rs1_val,
    input  logic [DATA_W-1:0] id_rs2_val,
    input  logic [DATA_W-1:0] id_imm,
    input  logic              id_use_imm,
    input  logic              id_uses_rs2,
    input  logic [OP_W-1:0]   id_alu_op,
    input  logic              id_is_load,
    input  logic              id_reg_write,
    input  logic [DATA_W-1:0] ex_fwd_result,
    input  logic [RA_W-1:0]   mem_rd,
    input  logic              mem_reg_write,
    input  logic [DATA_W-1:0] mem_result,
    input  logic [RA_W-1:0]   wb_rd,
    input  logic              wb_reg_write,
    input  logic [DATA_W-1:0] wb_result,
    input  logic              flush,
    input  logic              hold,
    output logic [DATA_W-1:0] ex_a,
    output logic [DATA_W-1:0] ex_b,
    output logic [DATA_W-1:0] ex_store_data,
    output logic [OP_W-1:0]   ex_op,
    output logic [RA_W-1:0]   ex_rd,
    output logic              ex_valid,
    output logic              ex_is_load,
    output logic              ex_reg_write,
    output logic              stall_id
);

    logic [DATA_W-1:0] ex_a_q, ex_a_d, ex_b_q, ex_b_d, ex_sd_q, ex_sd_d;
    logic [OP_W-1:0]   ex_op_q, ex_op_d;
    logic [RA_W-1:0]   ex_rd_q, ex_rd_d;
    logic              ex_valid_q, ex_valid_d, ex_is_load_q, ex_is_load_d;
    logic              ex_reg_write_q, ex_reg_write_d;
    logic [DATA_W-1:0] rs1_fwd, rs2_fwd;
    logic              ex_fwd_en, load_use;

    // A load's value is not ready in EX, so it cannot be forwarded from there.
    assign ex_fwd_en = ex_valid_q & ex_reg_write_q & ~ex_is_load_q;

    fwd_mux #(.DATA_W(DATA_W), .RA_W(RA_W)) u_fwd_rs1 (
        .rs_i      (id_rs1),
        .rf_val_i  (id_rs1_val),
        .ex_en_i   (ex_fwd_en),
        .ex_rd_i   (ex_rd_q),
        .ex_val_i  (ex_fwd_result),
        .mem_en_i  (mem_reg_write),
        .mem_rd_i  (mem_rd),
        .mem_val_i (mem_result),
        .wb_en_i   (wb_reg_write),
        .wb_rd_i   (wb_rd),
        .wb_val_i  (wb_result),
        .val_o     (rs1_fwd)
    );

    fwd_mux #(.DATA_W(DATA_W), .RA_W(RA_W)) u_fwd_rs2 (
        .rs_i      (id_rs2),
        .rf_val_i  (id_rs2_val),
        .ex_en_i   (ex_fwd_en),
        .ex_rd_i   (ex_rd_q),
        .ex_val_i  (ex_fwd_result),
        .mem_en_i  (mem_reg_write),
        .mem_rd_i  (mem_rd),
        .mem_val_i (mem_result),
        .wb_en_i   (wb_reg_write),
        .wb_rd_i   (wb_rd),
        .wb_val_i  (wb_result),
        .val_o     (rs2_fwd)
    );

    // Load in EX feeding the instruction in ID; stall is masked while in reset.
    always_comb begin
        load_use = id_valid & ex_valid_q & ex_is_load_q &
                   (ex_rd_q != RA_W'(dlx_pipe_pkg::REG_ZERO)) &
                   ((ex_rd_q == id_rs1) | (id_uses_rs2 & (ex_rd_q == id_rs2)));
        stall_id = ~reset & (hold | load_use);
    end

    // Next EX contents: hold > flush > load-use bubble > normal capture.
    always_comb begin
        ex_a_d         = rs1_fwd;
        ex_b_d         = id_use_imm ? id_imm : rs2_fwd;
        ex_sd_d        = rs2_fwd;
        ex_op_d        = id_alu_op;
        ex_rd_d        = id_rd;
        ex_valid_d     = id_valid;
        ex_is_load_d   = id_is_load & id_valid;
        ex_reg_write_d = id_reg_write & id_valid;
        if (hold) begin
            ex_a_d         = ex_a_q;
            ex_b_d         = ex_b_q;
            ex_sd_d        = ex_sd_q;
            ex_op_d        = ex_op_q;
            ex_rd_d        = ex_rd_q;
            ex_valid_d     = ex_valid_q;
            ex_is_load_d   = ex_is_load_q;
            ex_reg_write_d = ex_reg_write_q;
        end else if (flush || load_use) begin
            // Bubble: data fields are don't-care, control is cleared.
            ex_op_d        = '0;
            ex_valid_d     = 1'b0;
            ex_is_load_d   = 1'b0;
            ex_reg_write_d = 1'b0;
        end
    end

    // EX register bank with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_a_q         <= '0;
            ex_b_q         <= '0;
            ex_sd_q        <= '0;
            ex_op_q        <= '0;
            ex_rd_q        <= '0;
            ex_valid_q     <= 1'b0;
            ex_is_load_q   <= 1'b0;
            ex_reg_write_q <= 1'b0;
        end else begin
            ex_a_q         <= ex_a_d;
            ex_b_q         <= ex_b_d;
            ex_sd_q        <= ex_sd_d;
            ex_op_q        <= ex_op_d;
            ex_rd_q        <= ex_rd_d;
            ex_valid_q     <= ex_valid_d;
            ex_is_load_q   <= ex_is_load_d;
            ex_reg_write_q <= ex_reg_write_d;
        end
    end

    assign ex_a          = ex_a_q;
    assign ex_b          = ex_b_q;
    assign ex_store_data = ex_sd_q;
    assign ex_op         = ex_op_q;
    assign ex_rd         = ex_rd_q;
    assign ex_valid      = ex_valid_q;
    assign ex_is_load    = ex_is_load_q;
    assign ex_reg_write  = ex_reg_write_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Table-driven bench for id_ex_stage with a scoreboard for registered outputs.
module tb_id_ex_stage;
    import dlx_pipe_pkg::*;

    localparam int unsigned OP_AND = 32'(ALU_AND);
    localparam int unsigned OP_OR  = 32'(ALU_OR);
    localparam int unsigned OP_ADD = 32'(ALU_ADD);
    localparam int unsigned OP_SUB = 32'(ALU_SUB);
    localparam int unsigned OP_LHI = 32'(ALU_LHI);

    logic        clk = 1'b0;
    logic        reset, id_valid, id_use_imm, id_uses_rs2, id_is_load, id_reg_write;
    logic [4:0]  id_rs1, id_rs2, id_rd, id_alu_op, mem_rd, wb_rd;
    logic [31:0] id_rs1_val, id_rs2_val, id_imm, ex_fwd_result, mem_result, wb_result;
    logic        mem_reg_write, wb_reg_write, flush, hold;
    logic [31:0] ex_a, ex_b, ex_store_data;
    logic [4:0]  ex_op, ex_rd;
    logic        ex_valid, ex_is_load, ex_reg_write, stall_id;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rd(id_rd), .id_rs1_val(id_rs1_val), .id_rs2_val(id_rs2_val), .id_imm(id_imm),
        .id_use_imm(id_use_imm), .id_uses_rs2(id_uses_rs2), .id_alu_op(id_alu_op),
        .id_is_load(id_is_load), .id_reg_write(id_reg_write), .ex_fwd_result(ex_fwd_result),
        .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_result(mem_result),
        .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_result(wb_result),
        .flush(flush), .hold(hold), .ex_a(ex_a), .ex_b(ex_b), .ex_store_data(ex_store_data),
        .ex_op(ex_op), .ex_rd(ex_rd), .ex_valid(ex_valid), .ex_is_load(ex_is_load),
        .ex_reg_write(ex_reg_write), .stall_id(stall_id)
    );

    typedef struct {
        logic        rst, hold, flush, vld, use_imm, uses_rs2, ld, rw, mwe, wwe;
        logic [4:0]  rs1, rs2, rd, op, mrd, wrd;
        logic [31:0] rs1v, rs2v, imm, exf, mres, wres;
        logic        e_stall, e_chk, e_vld, e_ld, e_rw;
        logic [31:0] e_a, e_b, e_sd;
        logic [4:0]  e_op, e_rd;
    } vec_t;

    vec_t v;
    vec_t vecs[$];
    vec_t sb[$];
    int   total = 0;
    int   bad = 0;

    function automatic vec_t blank();
        vec_t b;
        b.rst = 0; b.hold = 0; b.flush = 0; b.vld = 0; b.use_imm = 0; b.uses_rs2 = 0;
        b.ld = 0; b.rw = 0; b.mwe = 0; b.wwe = 0; b.rs1 = 0; b.rs2 = 0; b.rd = 0; b.op = 0;
        b.mrd = 0; b.wrd = 0; b.rs1v = 0; b.rs2v = 0; b.imm = 0; b.exf = 0; b.mres = 0;
        b.wres = 0; b.e_stall = 0; b.e_chk = 1; b.e_vld = 0; b.e_ld = 0; b.e_rw = 0;
        b.e_a = 0; b.e_b = 0; b.e_sd = 0; b.e_op = 0; b.e_rd = 0;
        return b;
    endfunction

    // Start a new vector with a valid ID instruction.
    task automatic id_i(input int unsigned rs1, input int unsigned rs1v, input int unsigned rs2,
                        input int unsigned rs2v, input int unsigned imm, input int unsigned ui,
                        input int unsigned ur2, input int unsigned op, input int unsigned rd,
                        input int unsigned ld, input int unsigned rw);
        v = blank();
        v.vld = 1; v.rs1 = 5'(rs1); v.rs1v = rs1v; v.rs2 = 5'(rs2); v.rs2v = rs2v;
        v.imm = imm; v.use_imm = 1'(ui); v.uses_rs2 = 1'(ur2); v.op = 5'(op);
        v.rd = 5'(rd); v.ld = 1'(ld); v.rw = 1'(rw);
    endtask

    task automatic exp(input int unsigned st, input int unsigned a, input int unsigned b,
                       input int unsigned sd, input int unsigned op, input int unsigned rd,
                       input int unsigned vl, input int unsigned ld, input int unsigned rw);
        v.e_stall = 1'(st); v.e_chk = 1; v.e_a = a; v.e_b = b; v.e_sd = sd;
        v.e_op = 5'(op); v.e_rd = 5'(rd); v.e_vld = 1'(vl); v.e_ld = 1'(ld); v.e_rw = 1'(rw);
        vecs.push_back(v);
    endtask

    task automatic bub(input int unsigned st);
        v.e_stall = 1'(st); v.e_chk = 0; v.e_op = 0; v.e_vld = 0; v.e_ld = 0; v.e_rw = 0;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, want);
        end
    endtask

    // Drive one cycle; stall_id is checked combinationally, EX outputs after the edge.
    task automatic apply(input int idx, input vec_t x);
        vec_t e;
        reset = x.rst; hold = x.hold; flush = x.flush; id_valid = x.vld;
        id_rs1 = x.rs1; id_rs2 = x.rs2; id_rd = x.rd; id_rs1_val = x.rs1v;
        id_rs2_val = x.rs2v; id_imm = x.imm; id_use_imm = x.use_imm;
        id_uses_rs2 = x.uses_rs2; id_alu_op = x.op; id_is_load = x.ld; id_reg_write = x.rw;
        ex_fwd_result = x.exf; mem_rd = x.mrd; mem_reg_write = x.mwe; mem_result = x.mres;
        wb_rd = x.wrd; wb_reg_write = x.wwe; wb_result = x.wres;
        #1;
        chk($sformatf("v%0d.stall", idx), 32'(stall_id), 32'(x.e_stall));
        sb.push_back(x);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            total++; bad++;
            $display("FAIL v%0d.scoreboard: got empty want entry", idx);
        end else begin
            e = sb.pop_front();
            chk($sformatf("v%0d.valid", idx), 32'(ex_valid), 32'(e.e_vld));
            chk($sformatf("v%0d.is_load", idx), 32'(ex_is_load), 32'(e.e_ld));
            chk($sformatf("v%0d.reg_write", idx), 32'(ex_reg_write), 32'(e.e_rw));
            chk($sformatf("v%0d.op", idx), 32'(ex_op), 32'(e.e_op));
            if (e.e_chk) begin
                chk($sformatf("v%0d.a", idx), ex_a, e.e_a);
                chk($sformatf("v%0d.b", idx), ex_b, e.e_b);
                chk($sformatf("v%0d.sd", idx), ex_store_data, e.e_sd);
                chk($sformatf("v%0d.rd", idx), 32'(ex_rd), 32'(e.e_rd));
            end
        end
    endtask

    initial begin
        // Reset (with hold high) clears everything and keeps stall low.
        v = blank(); v.rst = 1; v.hold = 1; exp(0, 0, 0, 0, 0, 0, 0, 0, 0);
        // Plain R-type, no forwarding.
        id_i(1, 7, 2, 9, 0, 0, 1, OP_ADD, 3, 0, 1); exp(0, 7, 9, 9, OP_ADD, 3, 1, 0, 1);
        // EX forward on rs1; r0 on rs2 reads the file; immediate drives B.
        id_i(3, 5, 0, 'h22, 'h44, 1, 0, OP_ADD, 6, 0, 1); v.exf = 'h10;
        exp(0, 'h10, 'h44, 'h22, OP_ADD, 6, 1, 0, 1);
        // MEM beats WB on the same register.
        id_i(1, 1, 4, 'h33, 0, 0, 1, OP_SUB, 7, 0, 1); v.exf = 'h99;
        v.mrd = 4; v.mwe = 1; v.mres = 'hAA; v.wrd = 4; v.wwe = 1; v.wres = 'hBB;
        exp(0, 1, 'hAA, 'hAA, OP_SUB, 7, 1, 0, 1);
        // EX beats MEM on rs1, WB alone on rs2.
        id_i(7, 0, 8, 0, 0, 0, 1, OP_OR, 10, 0, 1); v.exf = 'h77;
        v.mrd = 7; v.mwe = 1; v.mres = 'hCC; v.wrd = 8; v.wwe = 1; v.wres = 'hBB;
        exp(0, 'h77, 'hBB, 'hBB, OP_OR, 10, 1, 0, 1);
        // Writes to r0 are never forwarded.
        id_i(0, 0, 0, 5, 0, 0, 1, OP_AND, 11, 0, 1); v.exf = 'h12;
        v.mrd = 0; v.mwe = 1; v.mres = 'hFF; v.wrd = 0; v.wwe = 1; v.wres = 'hEE;
        exp(0, 0, 5, 5, OP_AND, 11, 1, 0, 1);
        // Load r5, then a dependent instruction stalls once and retries from MEM.
        id_i(1, 'h100, 0, 0, 4, 1, 0, OP_ADD, 5, 1, 1); exp(0, 'h100, 4, 0, OP_ADD, 5, 1, 1, 1);
        id_i(5, 1, 2, 3, 0, 0, 1, OP_ADD, 12, 0, 1); v.exf = 'hDEAD; bub(1);
        id_i(5, 1, 2, 3, 0, 0, 1, OP_ADD, 12, 0, 1); v.exf = 'hDEAD;
        v.mrd = 5; v.mwe = 1; v.mres = 'h55; exp(0, 'h55, 3, 3, OP_ADD, 12, 1, 0, 1);
        // hold+flush for three cycles: EX frozen; then flush alone inserts a bubble.
        for (int k = 0; k < 3; k++) begin
            id_i(1, 9, 0, 0, 0, 0, 0, OP_ADD, 13, 0, 1); v.hold = 1; v.flush = 1;
            exp(1, 'h55, 3, 3, OP_ADD, 12, 1, 0, 1);
        end
        id_i(1, 9, 0, 0, 0, 0, 0, OP_ADD, 13, 0, 1); v.flush = 1; bub(0);
        // Invalid ID instruction: control gated, op still captured.
        id_i(0, 3, 0, 4, 0, 0, 1, OP_LHI, 14, 1, 1); v.vld = 0;
        exp(0, 3, 4, 4, OP_LHI, 14, 0, 0, 0);
        // Load r5 then reset while the dependent instruction would stall.
        id_i(0, 'h200, 0, 0, 0, 1, 0, OP_ADD, 5, 1, 1); exp(0, 'h200, 0, 0, OP_ADD, 5, 1, 1, 1);
        id_i(5, 7, 0, 0, 0, 0, 1, OP_ADD, 12, 0, 1); v.rst = 1;
        exp(0, 0, 0, 0, 0, 0, 0, 0, 0);
        id_i(5, 7, 0, 0, 0, 0, 1, OP_ADD, 12, 0, 1); exp(0, 7, 0, 0, OP_ADD, 12, 1, 0, 1);

        for (int i = 0; i < vecs.size(); i++) apply(i, vecs[i]);

        // Hand sequence: rs2 hazard only counts when the instruction reads rs2.
        vecs.delete();
        id_i(0, 'h10, 0, 0, 8, 1, 0, OP_ADD, 6, 1, 1); exp(0, 'h10, 8, 0, OP_ADD, 6, 1, 1, 1);
        id_i(1, 2, 6, 3, 1, 1, 0, OP_ADD, 13, 0, 1); v.exf = 'hBAD;
        exp(0, 2, 1, 3, OP_ADD, 13, 1, 0, 1);
        id_i(0, 0, 0, 0, 0, 1, 0, OP_ADD, 6, 1, 1); exp(0, 0, 0, 0, OP_ADD, 6, 1, 1, 1);
        id_i(1, 2, 6, 3, 0, 0, 1, OP_ADD, 13, 0, 1); bub(1);
        id_i(1, 2, 6, 3, 0, 0, 1, OP_ADD, 13, 0, 1); exp(0, 2, 3, 3, OP_ADD, 13, 1, 0, 1);
        for (int i = 0; i < vecs.size(); i++) apply(100 + i, vecs[i]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
